// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select through channels 0..3,
// waits SETTLE cycles on each, samples y, and hands the 4-bit snapshot
// downstream on a valid/ready handshake. Single-shot or continuous scan.
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic [1:0] s,
  input  logic       y,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       s_n;
  logic [3:0]       data_n;
  logic             valid_n;
  logic             busy_n;
  // Channels 0..2 are buffered here; channel 3 goes straight into data.
  logic [2:0]       shadow, shadow_n;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      s      <= '0;
      cnt    <= '0;
      data   <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      shadow <= '0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      cnt    <= cnt_n;
      data   <= data_n;
      valid  <= valid_n;
      busy   <= busy_n;
      shadow <= shadow_n;
    end
  end

  // Next-state and next-output decode for the scan sequence.
  always_comb begin
    state_n  = state;
    s_n      = s;
    cnt_n    = cnt;
    data_n   = data;
    valid_n  = valid;
    shadow_n = shadow;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SETTLE;
          s_n     = '0;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (s != 2'd3) begin
          shadow_n[s] = y;
          s_n         = s + 2'd1;
          cnt_n       = CNT_LOAD;
        end else begin
          data_n  = {y, shadow};
          valid_n = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          valid_n = 1'b0;
          if (cont) begin
            state_n = ST_SETTLE;
            s_n     = '0;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // busy is registered from the next state so it lines up with state.
    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: two builds (SETTLE=2 and SETTLE=0)
// share stimulus; a timing-based reference model predicts both every cycle.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cont, ready;
  logic [3:0] mux_in;

  logic [1:0] s_a, s_b;
  logic [3:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;
  logic       y_a, y_b;

  assign y_a = mux_in[s_a];
  assign y_b = mux_in[s_b];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SETTLE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .s(s_a), .y(y_a),
    .data(data_a), .valid(valid_a), .ready(ready), .busy(busy_a)
  );

  mux_scan_ctrl #(.SETTLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .s(s_b), .y(y_b),
    .data(data_b), .valid(valid_b), .ready(ready), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 scanning, 2 holding a word.
  // Scan timing is derived from edges elapsed since the start edge.
  int         m_mode[2];
  int         m_t[2];
  logic [1:0] m_s[2];
  logic [3:0] m_word[2];
  logic [3:0] m_data[2];
  logic       m_valid[2];
  int         xfer[2];
  logic [3:0] words_a[$];

  typedef struct {
    logic       start;
    logic       cont;
    logic       ready;
    logic [3:0] mux;
    logic [1:0] s;
    logic       valid;
    logic       busy;
    logic [3:0] data;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_t[k] = 0; m_s[k] = '0;
      m_word[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    int p;
    int ch;
    p = (k == 0) ? 3 : 1;
    case (m_mode[k])
      0: if (start) begin m_mode[k] = 1; m_t[k] = 0; m_s[k] = '0; end
      1: begin
        m_t[k]++;
        if (m_t[k] % p == 0) begin
          ch = m_t[k] / p - 1;
          m_word[k][ch] = mux_in[m_s[k]];
          if (ch == 3) begin
            m_data[k] = m_word[k]; m_valid[k] = 1'b1; m_mode[k] = 2;
          end else begin
            m_s[k] = 2'(ch + 1);
          end
        end
      end
      default: if (ready) begin
        m_valid[k] = 1'b0;
        if (cont) begin m_mode[k] = 1; m_t[k] = 0; m_s[k] = '0; end
        else m_mode[k] = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("s_a", 32'(s_a), 32'(m_s[0]));
    chk("valid_a", 32'(valid_a), 32'(m_valid[0]));
    chk("busy_a", 32'(busy_a), 32'(m_mode[0] != 0));
    chk("data_a", 32'(data_a), 32'(m_data[0]));
    chk("s_b", 32'(s_b), 32'(m_s[1]));
    chk("valid_b", 32'(valid_b), 32'(m_valid[1]));
    chk("busy_b", 32'(busy_b), 32'(m_mode[1] != 0));
    chk("data_b", 32'(data_b), 32'(m_data[1]));
  endtask

  // One clock edge: log transfers, advance the model, then check after the edge.
  task automatic step();
    if (valid_a && ready) begin xfer[0]++; words_a.push_back(data_a); end
    if (valid_b && ready) xfer[1]++;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_s_a", 32'(s_a), 0);
    chk("rst_valid_a", 32'(valid_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_data_a", 32'(data_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    start = 1'b0; cont = 1'b0; ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
  endtask

  initial begin
    // Single scan with SETTLE=2: select steps at E0/E3/E6/E9, word at E12, taken at E13.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 4'b1010};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b1010, 2'd3, 1'b0, 1'b0, 4'b1010};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b0; mux_in = '0;
    xfer[0] = 0; xfer[1] = 0;
    model_reset();
    #23;
    chk("init_s_a", 32'(s_a), 0);
    chk("init_valid_a", 32'(valid_a), 0);
    chk("init_busy_a", 32'(busy_a), 0);
    chk("init_data_a", 32'(data_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed single scan from the table.
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; cont = tbl[i].cont; ready = tbl[i].ready; mux_in = tbl[i].mux;
      step();
      chk($sformatf("tbl%0d_s", i), 32'(s_a), 32'(tbl[i].s));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_data", i), 32'(data_a), 32'(tbl[i].data));
    end
    drain();

    // Asynchronous reset in the middle of SETTLE wipes the held word too.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    async_reset();
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_idle_a", 32'(busy_a), 0);

    // Backpressure: word held for 20 cycles, then exactly one transfer.
    ready = 1'b0; mux_in = 4'b1100; xfer[0] = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("bp_valid_rise", 32'(valid_a), 1);
    mux_in = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_data", 32'(data_a), 32'(4'b1100));
      chk("bp_hold_s", 32'(s_a), 3);
    end
    ready = 1'b1; step(); ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_one_xfer", 32'(xfer[0]), 1);
    chk("bp_idle", 32'(busy_a), 0);
    drain();

    // Continuous mode: 0101 then 1111, rescan starts on the accepting edge.
    words_a.delete();
    cont = 1'b1; ready = 1'b1; mux_in = 4'b0101;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40 && words_a.size() < 1; i++) step();
    chk("cont_first_seen", 32'(words_a.size()), 1);
    chk("cont_no_idle_busy", 32'(busy_a), 1);
    chk("cont_restart_s", 32'(s_a), 0);
    mux_in = 4'b1111; cont = 1'b0;
    for (int i = 0; i < 40 && words_a.size() < 2; i++) step();
    chk("cont_two_words", 32'(words_a.size()), 2);
    if (words_a.size() >= 2) begin
      chk("cont_word0", 32'(words_a[0]), 32'(4'b0101));
      chk("cont_word1", 32'(words_a[1]), 32'(4'b1111));
    end
    step();
    chk("cont_end_idle", 32'(busy_a), 0);
    drain();

    // SETTLE=0 build: four consecutive samples, word after E4.
    ready = 1'b0; mux_in = 4'b0110;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("s0_not_yet", 32'(valid_b), 0);
    step();
    chk("s0_valid_e4", 32'(valid_b), 1);
    chk("s0_data", 32'(data_b), 32'(4'b0110));
    drain();

    // start pulses mid-scan are ignored; dropping cont yields one word then idle.
    xfer[0] = 0; ready = 1'b1; cont = 1'b1; mux_in = 4'b1001;
    start = 1'b1; step();
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0) && (i < 12);
      cont = (i < 5);
      step();
    end
    start = 1'b0;
    chk("drop_cont_one_word", 32'(xfer[0]), 1);
    chk("drop_cont_idle", 32'(busy_a), 0);

    // Random traffic against the model, with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) mux_in = 4'($urandom);
      if (i == 1500) async_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
